// File: rtl/icache_nway_wide.sv
// icache_nway_wide: N-way set-associative, read-only instruction cache.
// Whole lines are filled in one beat over a wide memory read port.
// Replacement prefers the lowest-numbered invalid way, then a per-set
// round-robin pointer. A one-cycle flush invalidates every line.
// Optional build macro ICACHE_STATS_EN adds hit_count, miss_count and
// occupancy outputs. Without the macro those ports and counters do not exist.
//
// Handshakes:
//   proc_valid/proc_ready - the core holds proc_valid and proc_addr until it
//     sees the single-cycle proc_ready pulse. proc_rdata is valid in that same
//     cycle. A new request is accepted only after proc_valid has been low for
//     at least one cycle. The core may also withdraw proc_valid during a miss;
//     the fill still completes, but no proc_ready is given.
//   mem_req_valid/mem_req_ready - mem_req_valid and mem_req_addr stay stable
//     until memory raises mem_req_ready. Memory supplies the line on
//     mem_req_rdata in that same cycle. A reset may abandon an open request.
module icache_nway_wide #(
    parameter int CACHE_SIZE = 2048,
    parameter int NUM_WAYS   = 2,
    parameter int NUM_BLOCKS = 4,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                flush,
    input  logic                                proc_valid,
    input  logic [31:0]                         proc_addr,
    output logic                                proc_ready,
    output logic [8*BLOCK_SIZE-1:0]             proc_rdata,
    output logic                                mem_req_valid,
    input  logic                                mem_req_ready,
    output logic [31:0]                         mem_req_addr,
    input  logic [8*BLOCK_SIZE*NUM_BLOCKS-1:0]  mem_req_rdata,
    output logic [1:0]                          dbg_state
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                         hit_count,
    output logic [31:0]                         miss_count,
    output logic [31:0]                         occupancy
`endif
);

    localparam int WORD_W = 8 * BLOCK_SIZE;
    localparam int LINE_W = WORD_W * NUM_BLOCKS;
    localparam int SETS   = CACHE_SIZE / (NUM_WAYS * NUM_BLOCKS * BLOCK_SIZE);
    localparam int IDX    = $clog2(SETS);
    localparam int OFF    = $clog2(NUM_BLOCKS);
    localparam int BOFF   = $clog2(BLOCK_SIZE);
    localparam int TAG    = 32 - IDX - OFF - BOFF;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MISS = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [31:0]       miss_addr_q;

    logic [SETS-1:0]   valid_q [NUM_WAYS];
    logic [TAG-1:0]    tag_q   [NUM_WAYS][SETS];
    logic [LINE_W-1:0] data_q  [NUM_WAYS][SETS];
    logic [WAY_W-1:0]  rr_q    [SETS];

    // Fields of the live request (lookup) and of the latched miss (install)
    logic [TAG-1:0]    req_tag;
    logic [IDX-1:0]    req_idx;
    logic [OFF-1:0]    req_word;
    logic [TAG-1:0]    lat_tag;
    logic [IDX-1:0]    lat_idx;
    logic [OFF-1:0]    lat_word;

    assign req_tag  = proc_addr[31 -: TAG];
    assign req_idx  = proc_addr[OFF+BOFF +: IDX];
    assign req_word = proc_addr[BOFF +: OFF];
    assign lat_tag  = miss_addr_q[31 -: TAG];
    assign lat_idx  = miss_addr_q[OFF+BOFF +: IDX];
    assign lat_word = miss_addr_q[BOFF +: OFF];

    // Byte-offset bits never affect a whole-word fetch
    logic unused_addr_bits;
    assign unused_addr_bits = ^{proc_addr[BOFF-1:0], miss_addr_q[BOFF-1:0]};

    assign dbg_state = state;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [LINE_W-1:0] hit_line;
    logic [WORD_W-1:0] hit_word;
    logic [WORD_W-1:0] fill_word;
    logic              any_inv;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  rr_next;
    logic              install;

    // Tag compare across all ways; scanning downwards makes the lowest matching way win
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_line = data_q[hit_way][req_idx];

    // Word selection from the hit line and from the incoming fill line
    always_comb begin
        hit_word  = '0;
        fill_word = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            if (req_word == OFF'(k)) hit_word = hit_line[k*WORD_W +: WORD_W];
            if (lat_word == OFF'(k)) fill_word = mem_req_rdata[k*WORD_W +: WORD_W];
        end
    end

    // Victim choice: lowest-numbered invalid way first, otherwise the set's RR pointer
    always_comb begin
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][lat_idx]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        victim  = any_inv ? inv_way : rr_q[lat_idx];
        rr_next = (rr_q[lat_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[lat_idx] + 1'b1;
    end

    // A line is written only when memory answers and no flush competes in that cycle
    assign install = (state == S_MISS) && mem_req_ready && !flush;

    // Request FSM and registered core/memory outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            proc_ready    <= 1'b0;
            proc_rdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            miss_addr_q   <= '0;
        end else begin
            proc_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (proc_valid) begin
                        // A same-cycle flush hides the hit, so the request goes to memory
                        if (hit && !flush) begin
                            proc_ready <= 1'b1;
                            proc_rdata <= hit_word;
                            state      <= S_DONE;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {proc_addr[31:OFF+BOFF], {(OFF+BOFF){1'b0}}};
                            miss_addr_q   <= proc_addr;
                            state         <= S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (proc_valid) begin
                            proc_ready <= 1'b1;
                            proc_rdata <= fill_word;
                            state      <= S_DONE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    if (!proc_valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Valid bits and round-robin pointers; flush outranks any install
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (flush) begin
            for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
        end else if (install) begin
            valid_q[victim][lat_idx] <= 1'b1;
            if (!any_inv) rr_q[lat_idx] <= rr_next;
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them
    always_ff @(posedge clk) begin
        if (resetn && install) begin
            tag_q[victim][lat_idx]  <= lat_tag;
            data_q[victim][lat_idx] <= mem_req_rdata;
        end
    end

`ifdef ICACHE_STATS_EN
    // Event counters; occupancy tracks newly valid lines and is cleared by flush
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_count  <= '0;
            miss_count <= '0;
            occupancy  <= '0;
        end else begin
            if (state == S_IDLE && proc_valid && hit && !flush) hit_count <= hit_count + 32'd1;
            if (state == S_IDLE && proc_valid && !(hit && !flush)) miss_count <= miss_count + 32'd1;
            if (flush) occupancy <= '0;
            else if (install && any_inv) occupancy <= occupancy + 32'd1;
        end
    end
`endif

endmodule
